// File: rtl/ibex_fetch_align_fifo.sv
// Fetch word FIFO with halfword aligner that presents one instruction at pc_q to the decoder.
// Define IBEX_FETCH_ERR_EN to track per-word bus errors and report them on out_err_o.
module ibex_fetch_align_fifo #(
   parameter int DEPTH = 3
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   input  logic [31:0] clear_addr_i,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_rdata_o,
   output logic [31:0] out_addr_o,
   output logic        out_is_compressed_o,
   output logic        out_err_o,
   output logic        busy_o
);

   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]   data_q [DEPTH];
   logic [31:0]   data_d [DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   pc_q, pc_d;

   logic [15:0]   lo_half;
   logic          is_comp;
   logic          out_valid;
   logic          out_err;
   logic [31:0]   out_rdata;
   logic          err0;
   logic          err1;
   logic          fire;
   logic          pop;
   logic          push;
   logic [CW-1:0] wr_idx;
   logic          unused_addr;

   assign unused_addr = clear_addr_i[0];

`ifdef IBEX_FETCH_ERR_EN
   logic [DEPTH-1:0] err_q, err_d;

   assign err0 = err_q[0];
   assign err1 = err_q[1];
`else
   logic unused_err;

   assign unused_err = in_err_i;
   assign err0       = 1'b0;
   assign err1       = 1'b0;
`endif

   // Instruction selection from the oldest one or two words at the current halfword offset
   always_comb begin
      lo_half = pc_q[1] ? data_q[0][31:16] : data_q[0][15:0];
      is_comp = (lo_half[1:0] != 2'b11);
      if (!pc_q[1]) begin
         out_rdata = data_q[0];
         out_valid = (count_q >= CW'(1));
         out_err   = err0;
      end else if (is_comp) begin
         out_rdata = {16'h0000, data_q[0][31:16]};
         out_valid = (count_q >= CW'(1));
         out_err   = err0;
      end else begin
         out_rdata = {data_q[1][15:0], data_q[0][31:16]};
         // An errored single word is released so a fault never waits on a word that may not come
         out_valid = (count_q >= CW'(2)) || (err0 && (count_q == CW'(1)));
         out_err   = err0 | err1;
      end
   end

   assign out_valid_o         = out_valid;
   assign out_rdata_o         = out_rdata;
   assign out_addr_o          = pc_q;
   assign out_is_compressed_o = is_comp;
   assign out_err_o           = out_err;
   assign in_ready_o          = (count_q < CW'(DEPTH));
   assign busy_o              = (count_q >= CW'(DEPTH - 1));

   // Handshakes, shift/write of entries, count and PC update
   always_comb begin
      fire   = out_valid && out_ready_i;
      // Only an aligned compressed instruction leaves part of entry 0 unconsumed
      pop    = fire && (pc_q[1] || !is_comp);
      push   = in_valid_i && (count_q < CW'(DEPTH)) && !clear_i;
      wr_idx = pop ? (count_q - CW'(1)) : count_q;

      for (int i = 0; i < DEPTH; i++) begin
         data_d[i] = (push && (CW'(i) == wr_idx)) ? in_rdata_i :
                     (pop ? data_q[(i < DEPTH - 1) ? i + 1 : i] : data_q[i]);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      if (fire) begin
         pc_d = pc_q + (is_comp ? 32'd2 : 32'd4);
      end else begin
         pc_d = pc_q;
      end

      if (clear_i) begin
         count_d = '0;
         pc_d    = {clear_addr_i[31:1], 1'b0};
      end else begin
         count_d = count_d;
      end
   end

`ifdef IBEX_FETCH_ERR_EN
   // Error flags follow the same shift/write pattern as the data words
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         err_d[i] = (push && (CW'(i) == wr_idx)) ? in_err_i :
                    (pop ? err_q[(i < DEPTH - 1) ? i + 1 : i] : err_q[i]);
      end
   end

   // Error flag storage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= '0;
      end else begin
         err_q <= err_d;
      end
   end
`endif

   // Word storage, occupancy and fetch PC
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         pc_q    <= 32'h0000_0000;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= 32'h0000_0000;
         end
      end else begin
         count_q <= count_d;
         pc_q    <= pc_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

endmodule

// File: tb/tb_ibex_fetch_align_fifo.sv
// Directed plus randomized check of ibex_fetch_align_fifo against a halfword-level queue model.
module tb_ibex_fetch_align_fifo;

   localparam int DEPTH = 3;
`ifdef IBEX_FETCH_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic [31:0] clear_addr = 32'h0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_rdata = 32'h0;
   logic        in_err = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_rdata;
   logic [31:0] out_addr;
   logic        out_comp;
   logic        out_err;
   logic        busy;

   always #5 clk = ~clk;

   ibex_fetch_align_fifo #(.DEPTH(DEPTH)) dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .clear_i             (clear),
      .clear_addr_i        (clear_addr),
      .in_valid_i          (in_valid),
      .in_ready_o          (in_ready),
      .in_rdata_i          (in_rdata),
      .in_err_i            (in_err),
      .out_valid_o         (out_valid),
      .out_ready_i         (out_ready),
      .out_rdata_o         (out_rdata),
      .out_addr_o          (out_addr),
      .out_is_compressed_o (out_comp),
      .out_err_o           (out_err),
      .busy_o              (busy)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: a queue of buffered words and the PC of the next instruction
   logic [31:0] m_words[$];
   bit          m_errs[$];
   logic [31:0] m_pc = 32'h0;

   bit          e_valid;
   bit          e_comp;
   bit          e_err;
   logic [31:0] e_rdata;
   logic [31:0] e_mask;
   int          e_need;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
      end
   endtask

   function automatic void model_eval();
      int          off;
      int          avail;
      logic [15:0] lo;
      e_valid = 1'b0;
      e_comp  = 1'b0;
      e_err   = 1'b0;
      e_rdata = 32'h0;
      e_mask  = 32'hFFFF_FFFF;
      e_need  = 1;
      if (m_words.size() == 0) return;
      off     = int'(m_pc[1]);
      lo      = (off == 1) ? m_words[0][31:16] : m_words[0][15:0];
      e_comp  = (lo[1:0] != 2'b11);
      e_need  = e_comp ? 1 : 2;
      avail   = 2 * m_words.size() - off;
      e_valid = (avail >= e_need);
      if (e_comp) begin
         e_mask  = 32'h0000_FFFF;
         e_rdata = {16'h0, lo};
      end else if (off == 0) begin
         e_rdata = m_words[0];
      end else if (m_words.size() > 1) begin
         e_rdata = {m_words[1][15:0], lo};
      end else begin
         e_mask  = 32'h0000_FFFF;
         e_rdata = {16'h0, lo};
      end
      e_err = m_errs[0] || ((off + e_need > 2) && (m_words.size() > 1) && m_errs[1]);
      if (ERR_EN && !e_valid && m_errs[0]) e_valid = 1'b1;
   endfunction

   task automatic check_outputs();
      model_eval();
      chk("out_valid", 32'(out_valid), 32'(e_valid));
      chk("out_addr", out_addr, m_pc);
      chk("in_ready", 32'(in_ready), 32'(m_words.size() < DEPTH));
      chk("busy", 32'(busy), 32'(m_words.size() >= DEPTH - 1));
      if (e_valid) begin
         chk("out_rdata", out_rdata & e_mask, e_rdata & e_mask);
         chk("out_comp", 32'(out_comp), 32'(e_comp));
         chk("out_err", 32'(out_err), 32'(e_err));
      end
   endtask

   task automatic model_update();
      int pops;
      bit do_push;
      do_push = in_valid && (m_words.size() < DEPTH);
      if (rst) begin
         m_words.delete();
         m_errs.delete();
         m_pc = 32'h0;
      end else if (clear) begin
         m_words.delete();
         m_errs.delete();
         m_pc = {clear_addr[31:1], 1'b0};
      end else begin
         if (e_valid && out_ready) begin
            pops = (int'(m_pc[1]) + e_need) / 2;
            for (int k = 0; k < pops; k++) begin
               void'(m_words.pop_front());
               void'(m_errs.pop_front());
            end
            m_pc = m_pc + 32'(2 * e_need);
         end
         if (do_push) begin
            m_words.push_back(in_rdata);
            m_errs.push_back(ERR_EN && in_err);
         end
      end
   endtask

   task automatic cycle();
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear(input logic [31:0] a);
      clear = 1'b1;
      clear_addr = a;
      cycle();
      clear = 1'b0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      cycle();
      rst = 1'b0;

      // Single 32-bit instruction at 0x100
      do_clear(32'h100);
      in_valid = 1'b1; in_rdata = 32'h00A00513;
      cycle();
      in_valid = 1'b0;
      chk("p1_valid", 32'(out_valid), 32'd1);
      chk("p1_addr", out_addr, 32'h100);
      chk("p1_rdata", out_rdata, 32'h00A00513);
      chk("p1_comp", 32'(out_comp), 32'd0);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("p1_empty", 32'(out_valid), 32'd0);
      chk("p1_addr2", out_addr, 32'h104);

      // Two compressed instructions in one word
      do_clear(32'h100);
      in_valid = 1'b1; in_rdata = 32'h45814501;
      cycle();
      in_valid = 1'b0;
      chk("p2_lo", {16'h0, out_rdata[15:0]}, 32'h4501);
      chk("p2_comp", 32'(out_comp), 32'd1);
      out_ready = 1'b1;
      cycle();
      chk("p2_hi", {16'h0, out_rdata[15:0]}, 32'h4581);
      chk("p2_addr", out_addr, 32'h102);
      cycle();
      out_ready = 1'b0;
      chk("p2_done", 32'(out_valid), 32'd0);
      chk("p2_pc", out_addr, 32'h104);

      // 32-bit instruction straddling two words
      do_clear(32'h102);
      in_valid = 1'b1; in_rdata = 32'h05134501;
      cycle();
      chk("p3_wait", 32'(out_valid), 32'd0);
      in_rdata = 32'h000000A0;
      cycle();
      in_valid = 1'b0;
      chk("p3_rdata", out_rdata, 32'h00A00513);
      chk("p3_addr", out_addr, 32'h102);
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("p3_pc", out_addr, 32'h106);
      chk("p3_busy", 32'(busy), 32'd0);

      // Full FIFO, push rejected during a pop
      do_clear(32'h300);
      in_valid = 1'b1; in_rdata = 32'h00A00513;
      for (int k = 0; k < DEPTH; k++) cycle();
      chk("p4_ready", 32'(in_ready), 32'd0);
      chk("p4_busy", 32'(busy), 32'd1);
      in_rdata = 32'h11111113;
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("p4_ready2", 32'(in_ready), 32'd1);
      chk("p4_busy2", 32'(busy), 32'd1);
      cycle();

      // Clear with push pending
      chk("p5_full", 32'(in_ready), 32'd0);
      clear = 1'b1; clear_addr = 32'h201;
      cycle();
      clear = 1'b0; in_valid = 1'b0;
      chk("p5_valid", 32'(out_valid), 32'd0);
      chk("p5_addr", out_addr, 32'h200);
      chk("p5_busy", 32'(busy), 32'd0);

      // Errored lone word at an unaligned PC
      do_clear(32'h102);
      in_valid = 1'b1; in_rdata = 32'hFFFF0000; in_err = 1'b1;
      cycle();
      in_valid = 1'b0; in_err = 1'b0;
      chk("p6_valid", 32'(out_valid), 32'(ERR_EN));
      chk("p6_err", 32'(out_err & out_valid), 32'(ERR_EN));
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      chk("p6_pc", out_addr, ERR_EN ? 32'h106 : 32'h102);

      // Randomized traffic against the model
      for (int n = 0; n < 2000; n++) begin
         rst        = ($urandom_range(0, 299) == 0);
         clear      = ($urandom_range(0, 39) == 0);
         clear_addr = $urandom;
         in_valid   = ($urandom_range(0, 2) != 0);
         in_rdata   = $urandom;
         in_err     = ($urandom_range(0, 11) == 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ibex_fetch_align_fifo.md
Name: ibex_fetch_align_fifo

Overview:
- Buffers word-aligned 32-bit fetch responses from the instruction memory interface.
- Extracts one instruction per handshake at the current fetch PC. An instruction may be 16-bit compressed or 32-bit uncompressed, and may sit at any halfword offset.
- Sits directly upstream of the compressed decoder. out_rdata_o drives the decoder's instr_i, and out_valid_o drives its valid_i.
- Handles 32-bit instructions that straddle two fetch words, and flushes on branch or jump redirect.

Parameters:
- DEPTH, 3, number of 32-bit word entries; legal range 2..8.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  flush all entries and load a new PC
- clear_addr_i  in  32  redirect PC; bit 0 ignored
- in_valid_i  in  1  fetch response word valid
- in_ready_o  out  1  FIFO can accept a word this cycle
- in_rdata_i  in  32  fetch response word
- in_err_i  in  1  bus error on this word
- out_valid_o  out  1  complete instruction available
- out_ready_i  in  1  downstream consumes instruction
- out_rdata_o  out  32  instruction; upper 16 bits are don't-care when compressed
- out_addr_o  out  32  PC of out_rdata_o, bit 0 always 0
- out_is_compressed_o  out  1  out_rdata_o[1:0] != 2'b11
- out_err_o  out  1  instruction touched an errored word
- busy_o  out  1  count >= DEPTH-1; fetch unit stops issuing requests

Behaviour:
- Storage
  - Entries are stored as data[DEPTH], err[DEPTH] and a count.
  - Entry 0 is the oldest word.
  - pc_q holds the current instruction address.
- Reset (rst_i high at a clock edge)
  - count=0, pc_q=0.
  - Outputs: out_valid_o=0, out_err_o=0, in_ready_o=1, busy_o=0.
  - Reset overrides clear_i and all handshakes in the same cycle.
- Push
  - Occurs when in_valid_i && in_ready_o. The word is written at index count, or at count-1 when entry 0 pops in the same cycle.
  - in_ready_o = (count < DEPTH). It does not look ahead to a same-cycle pop.
  - No bypass: a pushed word is visible at the output no earlier than the next cycle.
- Output selection, aligned (pc_q[1]=0)
  - out_rdata_o = data[0].
  - out_valid_o = count >= 1.
  - out_err_o = err[0].
- Output selection, unaligned (pc_q[1]=1)
  - Compressed, i.e. data[0][17:16] != 2'b11:
    - out_rdata_o = {16'b0, data[0][31:16]}.
    - out_valid_o = count >= 1.
  - Uncompressed:
    - out_rdata_o = {data[1][15:0], data[0][31:16]}.
    - out_valid_o = count >= 2.
    - out_err_o = err[0] | err[1].
  - Error word:
    - If err[0]=1 and count==1, output the instruction with out_valid_o=1 and out_err_o=1 regardless of the compressed check, so an error never deadlocks waiting for a second word.
- out_is_compressed_o
  - Derived from the selected low halfword.
  - out_addr_o = pc_q.
- Consume (out_valid_o && out_ready_i)
  - pc_q advances by 2 if compressed, else by 4. Addition wraps modulo 2^32.
  - Entry 0 pops (shift down, count-1) when:
    - aligned and uncompressed, or
    - unaligned and compressed, or
    - unaligned and uncompressed.
  - Aligned compressed does not pop.
- Simultaneous push and pop
  - count is unchanged.
  - The new word is written at the correct index after the shift.
- Clear
  - All entries are invalidated (count=0) and pc_q <= {clear_addr_i[31:1], 1'b0}.
  - A push in the same cycle is discarded.
  - A consume in the same cycle is ignored; pc_q takes the clear address.
  - out_valid_o=0 in the cycle after clear.
  - Words fetched before the redirect are discarded by the fetch unit, not by this block.
- Stability
  - While out_valid_o && !out_ready_i, all outputs hold stable.

Optional Feature:
- Macro: IBEX_FETCH_ERR_EN.
- Defined:
  - err[] storage is implemented.
  - out_err_o follows the rules above, including the single-word error release.
- Undefined:
  - No err storage.
  - in_err_i is ignored and out_err_o is constant 0.
  - An unaligned uncompressed instruction always waits for count >= 2.

Test Plan:
- Reset then clear_addr_i=0x100; push 0x00A00513 -> next cycle out_valid_o=1, out_addr_o=0x100, out_rdata_o=0x00A00513, out_is_compressed_o=0; after consume, count=0.
- Push 0x45814501 (two c.li) at pc 0x100 -> first out_rdata_o[15:0]=0x4501 at 0x100 with no pop; then 0x4581 at 0x102; then count=0 and pc=0x104.
- Clear to 0x102; push 0x05134501 then 0x000000A0 -> out_valid_o=0 after first word; after second word out_rdata_o=0x00A00513, addr=0x102; after consume pc=0x106, count=1.
- Fill DEPTH=3 words with out_ready_i=0 -> in_ready_o=0 and busy_o=1; assert out_ready_i with in_valid_i=1 -> push rejected that cycle, count=2 next.
- Three words buffered, assert clear_i=1 with clear_addr_i=0x201 and in_valid_i=1 -> count=0, pc_q=0x200, out_valid_o=0 next cycle.
- IBEX_FETCH_ERR_EN defined: clear to 0x102, push word 0xFFFF0000 with in_err_i=1 -> out_valid_o=1 and out_err_o=1 with count=1; undefined: out_valid_o stays 0.
